mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq.sv | 170 +++++++++++++++++
 tb/tb_mdu_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: sequential multiply/divide unit with HI/LO result registers.
// The result is computed at accept time and held in pending registers. It is
// committed to HI/LO after a fixed busy period of MULT_CYCLES or DIV_CYCLES.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   MDU_op[2:0]  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   A, B         rs / rt operands
//   req          exception/interrupt request; suppresses an op accepted this cycle
//   busy         multiply or divide in progress
//   done         one-cycle pulse after HI/LO receive a mult/div result
//   HI, LO       result registers
module mdu_seq #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       MDU_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned CW = 8;
  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH-1:0] pend_hi, pend_hi_nxt;
  logic [WIDTH-1:0] pend_lo, pend_lo_nxt;
  logic             pend_wr, pend_wr_nxt;
  logic             done_nxt;

  // Full-precision products; sign/zero extension to 2*WIDTH before multiplying.
  logic [PW-1:0] prod_s, prod_u;
  assign prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Signed division on magnitudes; the most-negative / -1 case falls out as
  // quotient = A, remainder = 0. A zero divisor is replaced by 1 so the
  // datapath stays defined; its result is never committed.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_div_s, b_div_u;
  logic [WIDTH-1:0] sq_mag, sr_mag, sq, sr, uq, ur;

  assign a_neg   = A[WIDTH-1];
  assign b_neg   = B[WIDTH-1];
  assign b_zero  = (B == '0);
  assign a_mag   = a_neg ? (WIDTH'(0) - A) : A;
  assign b_mag   = b_neg ? (WIDTH'(0) - B) : B;
  assign b_div_s = b_zero ? WIDTH'(1) : b_mag;
  assign b_div_u = b_zero ? WIDTH'(1) : B;
  assign sq_mag  = a_mag / b_div_s;
  assign sr_mag  = a_mag % b_div_s;
  assign sq      = (a_neg ^ b_neg) ? (WIDTH'(0) - sq_mag) : sq_mag;
  assign sr      = a_neg ? (WIDTH'(0) - sr_mag) : sr_mag;
  assign uq      = A / b_div_u;
  assign ur      = A % b_div_u;

  assign busy = (state == RUN);

  // Next-state, counter and register-update logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_nxt      = HI;
    lo_nxt      = LO;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;
    pend_wr_nxt = pend_wr;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (!req) begin
          case (MDU_op)
            OP_MULT: begin
              pend_hi_nxt = prod_s[PW-1:WIDTH];
              pend_lo_nxt = prod_s[WIDTH-1:0];
              pend_wr_nxt = 1'b1;
              cnt_nxt     = CW'(MULT_CYCLES);
              state_nxt   = RUN;
            end
            OP_MULTU: begin
              pend_hi_nxt = prod_u[PW-1:WIDTH];
              pend_lo_nxt = prod_u[WIDTH-1:0];
              pend_wr_nxt = 1'b1;
              cnt_nxt     = CW'(MULT_CYCLES);
              state_nxt   = RUN;
            end
            OP_DIV: begin
              pend_hi_nxt = sr;
              pend_lo_nxt = sq;
              pend_wr_nxt = !b_zero;
              cnt_nxt     = CW'(DIV_CYCLES);
              state_nxt   = RUN;
            end
            OP_DIVU: begin
              pend_hi_nxt = ur;
              pend_lo_nxt = uq;
              pend_wr_nxt = !b_zero;
              cnt_nxt     = CW'(DIV_CYCLES);
              state_nxt   = RUN;
            end
            OP_MTHI: hi_nxt = A;
            OP_MTLO: lo_nxt = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Commit at the edge where the counter reaches zero.
        if (cnt <= CW'(1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          if (pend_wr) begin
            hi_nxt = pend_hi;
            lo_nxt = pend_lo;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      HI      <= '0;
      LO      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      HI      <= hi_nxt;
      LO      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
      pend_wr <= pend_wr_nxt;
      done    <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq. Mult/div expectations are queued
// when issued and checked by a monitor on each done pulse; a second instance
// with MULT_CYCLES=1 covers the shortest latency.
module tb_mdu_seq;

  logic        clk;
  logic        reset;
  logic [2:0]  MDU_op;
  logic [31:0] A, B;
  logic        req;
  logic        busy, done;
  logic [31:0] HI, LO;

  logic [2:0]  op2;
  logic        busy2, done2;
  logic [31:0] HI2, LO2;

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_seen = 0;
  logic        done_d = 1'b0;
  logic [63:0] mon_e;
  logic [63:0] exp_q[$];

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .MDU_op(MDU_op), .A(A), .B(B), .req(req),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  mdu_seq #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut1 (
    .clk(clk), .reset(reset), .MDU_op(op2), .A(A), .B(B), .req(req),
    .busy(busy2), .done(done2), .HI(HI2), .LO(LO2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      done_seen++;
      chk("done_one_cycle", 64'(done_d), 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_hi", 64'(HI), 64'(mon_e[63:32]));
        chk("result_lo", 64'(LO), 64'(mon_e[31:0]));
      end
    end
    done_d = done;
  end

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int n,
                        input bit req_run, input bit late_mt, input string name);
    int cnt = 0;
    exp_q.push_back({ehi, elo});
    @(negedge clk);
    MDU_op = op; A = a; B = b; req = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) begin
        MDU_op = 3'd0; A = $urandom; B = $urandom; req = req_run;
      end
      if (busy !== 1'b1) break;
      cnt++;
      if (late_mt && cnt == n) begin
        MDU_op = 3'd5; A = 32'hDEADBEEF;
      end
    end
    MDU_op = 3'd0; req = 1'b0;
    chk({name, "_busy_cycles"}, 64'(cnt), 64'(n));
    chk({name, "_done_at_end"}, 64'(done), 64'd1);
    if (late_mt) begin
      @(negedge clk);
      chk({name, "_late_op_ignored"}, 64'(HI), 64'(ehi));
    end
  endtask

  task automatic mt_op(input logic [2:0] op, input logic [31:0] a, input bit r,
                       input logic [31:0] ehi, input logic [31:0] elo, input string name);
    @(negedge clk);
    MDU_op = op; A = a; req = r;
    @(negedge clk);
    MDU_op = 3'd0; req = 1'b0;
    chk({name, "_hi"}, 64'(HI), 64'(ehi));
    chk({name, "_lo"}, 64'(LO), 64'(elo));
    chk({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cnt2 = 0;
    reset = 1'b0; MDU_op = 3'd0; A = '0; B = '0; req = 1'b0; op2 = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(HI), 64'd0);
    chk("reset_lo", 64'(LO), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b1;

    run_op(3'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 0, 0, "mult");
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5, 0, 0, "multu");
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0, 0, "div_neg");
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, 0, 1, "div_ovf");

    mt_op(3'd5, 32'h1234, 1, 32'h0, 32'h80000000, "mthi_req");
    mt_op(3'd5, 32'h1234, 0, 32'h1234, 32'h80000000, "mthi");
    mt_op(3'd5, 32'd5, 0, 32'd5, 32'h80000000, "mthi5");
    mt_op(3'd6, 32'd6, 0, 32'd5, 32'd6, "mtlo6");

    run_op(3'd4, 32'd100, 32'd0, 32'd5, 32'd6, 10, 0, 0, "divu_zero");
    run_op(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1, 0, "divu_req_run");
    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 0, 0, "div_negdivisor");

    mt_op(3'd1, 32'd3, 1, 32'd1, 32'hFFFFFFFD, "mult_req");
    mt_op(3'd7, 32'd9, 0, 32'd1, 32'hFFFFFFFD, "op_reserved");

    // Reset in the second cycle of a MULT run aborts it without a write or done.
    @(negedge clk);
    MDU_op = 3'd1; A = 32'd3; B = 32'd4;
    @(negedge clk);
    MDU_op = 3'd0;
    chk("abort_started_busy", 64'(busy), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_hi", 64'(HI), 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b1; MDU_op = 3'd6; A = 32'h77;
    @(negedge clk);
    MDU_op = 3'd0;
    chk("first_edge_mtlo_lo", 64'(LO), 64'h77);
    chk("first_edge_mtlo_hi", 64'(HI), 64'd0);
    repeat (8) @(negedge clk);
    chk("abort_no_late_write", 64'(HI), 64'd0);

    // Single-cycle multiply on the MULT_CYCLES=1 instance.
    @(negedge clk);
    op2 = 3'd1; A = 32'd6; B = 32'd7;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 0) op2 = 3'd0;
      if (busy2 !== 1'b1) break;
      cnt2++;
    end
    chk("mult1_busy_cycles", 64'(cnt2), 64'd1);
    chk("mult1_done", 64'(done2), 64'd1);
    chk("mult1_hi", 64'(HI2), 64'd0);
    chk("mult1_lo", 64'(LO2), 64'd42);
    @(negedge clk);
    chk("mult1_done_cleared", 64'(done2), 64'd0);

    chk("pending_results", 64'(exp_q.size()), 64'd0);
    chk("done_count", 64'(done_seen), 64'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
